// File: rtl/dual_pe_wb_arbiter_pkg.sv
// Shared types and widths for the dual-PE writeback merge stage.
package dual_pe_wb_arbiter_pkg;

    localparam int XLEN          = 32;
    localparam int RADDR_W       = 5;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    wdata;
    } wb_entry_t;

    // A writeback is stored only if it really targets a writable register;
    // x0 writes and non-writing results complete the handshake and vanish.
    function automatic logic wb_accept(
        input logic               valid,
        input logic               ready,
        input logic               regwrite,
        input logic [RADDR_W-1:0] rd
    );
        return valid & ready & regwrite & (rd != '0);
    endfunction

endpackage

// File: rtl/dual_pe_wb_arbiter_if.sv
// PE writeback ports and the shared register-file write port of the merge stage.
interface dual_pe_wb_arbiter_if;
    import dual_pe_wb_arbiter_pkg::*;

    logic               pe0_wb_valid;
    logic               pe0_regwrite;
    logic [RADDR_W-1:0] pe0_rd;
    logic [XLEN-1:0]    pe0_wdata;
    logic               pe0_ready;

    logic               pe1_wb_valid;
    logic               pe1_regwrite;
    logic [RADDR_W-1:0] pe1_rd;
    logic [XLEN-1:0]    pe1_wdata;
    logic               pe1_ready;

    logic               rf_we;
    logic [RADDR_W-1:0] rf_addr;
    logic [XLEN-1:0]    rf_wdata;
    logic               rf_src;

    modport master (
        output pe0_wb_valid, pe0_regwrite, pe0_rd, pe0_wdata,
        output pe1_wb_valid, pe1_regwrite, pe1_rd, pe1_wdata,
        input  pe0_ready, pe1_ready,
        input  rf_we, rf_addr, rf_wdata, rf_src
    );

    modport slave (
        input  pe0_wb_valid, pe0_regwrite, pe0_rd, pe0_wdata,
        input  pe1_wb_valid, pe1_regwrite, pe1_rd, pe1_wdata,
        output pe0_ready, pe1_ready,
        output rf_we, rf_addr, rf_wdata, rf_src
    );

endinterface

// File: rtl/dual_pe_wb_arbiter_wb_fifo.sv
// Per-PE writeback FIFO: push/pop with full/empty derived from a registered count.
module wb_fifo
    import dual_pe_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  wb_entry_t data_i,
    input  logic      pop_i,
    output wb_entry_t data_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dual_pe_wb_arbiter.sv
// Merges two PE writeback streams into one register-file write port,
// round-robin between the per-PE FIFOs, and counts cycles of contention.
module dual_pe_wb_arbiter
    import dual_pe_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dual_pe_wb_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]     conflict_cnt_o
);
    logic [1:0]         wb_valid, regwrite, ready, empty, push, pop;
    logic [RADDR_W-1:0] rd_in [2];
    wb_entry_t          in_entry [2];
    wb_entry_t          head [2];
    logic               both_pending;

    logic               rr_q, rr_d;
    logic               rf_we_q, rf_we_d;
    logic [RADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
    logic               rf_src_q, rf_src_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign wb_valid    = {bus.pe1_wb_valid, bus.pe0_wb_valid};
    assign regwrite    = {bus.pe1_regwrite, bus.pe0_regwrite};
    assign rd_in[0]    = bus.pe0_rd;
    assign rd_in[1]    = bus.pe1_rd;
    assign in_entry[0] = '{rd: bus.pe0_rd, wdata: bus.pe0_wdata};
    assign in_entry[1] = '{rd: bus.pe1_rd, wdata: bus.pe1_wdata};

    assign bus.pe0_ready = ready[0];
    assign bus.pe1_ready = ready[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic full;
            assign ready[gi] = ~full;
            assign push[gi]  = wb_accept(wb_valid[gi], ready[gi], regwrite[gi], rd_in[gi]);

            wb_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .push_i  (push[gi]),
                .data_i  (in_entry[gi]),
                .pop_i   (pop[gi]),
                .data_o  (head[gi]),
                .full_o  (full),
                .empty_o (empty[gi])
            );
        end
    endgenerate

    // Arbitration looks only at registered FIFO state, so a fresh entry
    // always waits one edge before it can be written.
    always_comb begin
        both_pending = ~empty[0] & ~empty[1];
        pop          = 2'b00;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        rf_we_d      = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wdata_d   = rf_wdata_q;
        rf_src_d     = rf_src_q;

        if (both_pending) begin
            pop[rr_q] = 1'b1;
            rr_d      = ~rr_q;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (~empty[0]) begin
            pop[0] = 1'b1;
        end else if (~empty[1]) begin
            pop[1] = 1'b1;
        end

        if (pop[1]) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = head[1].rd;
            rf_wdata_d = head[1].wdata;
            rf_src_d   = 1'b1;
        end else if (pop[0]) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = head[0].rd;
            rf_wdata_d = head[0].wdata;
            rf_src_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            rf_src_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_src_q   <= rf_src_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.rf_src   = rf_src_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_dual_pe_wb_arbiter.sv
// Directed bench for the dual-PE writeback merge stage.
module tb_dual_pe_wb_arbiter;
    import dual_pe_wb_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] conflict_cnt;
    int               checks = 0;
    int               errors = 0;

    logic [RADDR_W+XLEN-1:0] exp_q0[$];
    logic [RADDR_W+XLEN-1:0] exp_q1[$];

    dual_pe_wb_arbiter_if bus();

    dual_pe_wb_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .conflict_cnt_o (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pe0(input logic v, input logic rw, input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] d);
        bus.pe0_wb_valid = v;
        bus.pe0_regwrite = rw;
        bus.pe0_rd       = rd;
        bus.pe0_wdata    = d;
    endtask

    task automatic set_pe1(input logic v, input logic rw, input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] d);
        bus.pe1_wb_valid = v;
        bus.pe1_regwrite = rw;
        bus.pe1_rd       = rd;
        bus.pe1_wdata    = d;
    endtask

    task automatic idle();
        set_pe0(1'b0, 1'b0, '0, '0);
        set_pe1(1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sb_sample();
        if (bus.rf_we) begin
            if (bus.rf_src == 1'b0) begin
                chk("bp_pe0_expected_pending", 64'(exp_q0.size() > 0), 1);
                if (exp_q0.size() > 0) chk("bp_pe0_entry", {bus.rf_addr, bus.rf_wdata}, exp_q0.pop_front());
            end else begin
                chk("bp_pe1_expected_pending", 64'(exp_q1.size() > 0), 1);
                if (exp_q1.size() > 0) chk("bp_pe1_entry", {bus.rf_addr, bus.rf_wdata}, exp_q1.pop_front());
            end
        end
    endtask

    initial begin
        int exp_rd [6];
        int p0;
        int p1;
        logic acc0;
        logic acc1;
        exp_rd = '{1, 9, 2, 10, 3, 11};

        // Reset state
        idle();
        #12;
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_rf_addr", bus.rf_addr, 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);
        chk("rst_rf_src", bus.rf_src, 0);
        chk("rst_conflict", conflict_cnt, 0);
        chk("rst_pe0_ready", bus.pe0_ready, 1);
        chk("rst_pe1_ready", bus.pe1_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single PE stream: rd 1..4, data 0x11..0x44
        for (int n = 1; n <= 6; n++) begin
            if (n <= 4) set_pe0(1'b1, 1'b1, 5'(n), 32'(n * 32'h11));
            else idle();
            tick();
            if (n == 1) begin
                chk("single_no_bypass", bus.rf_we, 0);
            end else if (n <= 5) begin
                chk("single_we", bus.rf_we, 1);
                chk("single_addr", bus.rf_addr, n - 1);
                chk("single_data", bus.rf_wdata, (n - 1) * 32'h11);
                chk("single_src", bus.rf_src, 0);
            end else begin
                chk("single_idle_we", bus.rf_we, 0);
                chk("single_idle_addr_hold", bus.rf_addr, 4);
            end
        end
        chk("single_conflict", conflict_cnt, 0);

        // Drops: rd=0, then regwrite=0
        do_reset();
        set_pe0(1'b1, 1'b1, 5'd0, 32'hDEAD);
        tick();
        chk("drop_rd0_ready", bus.pe0_ready, 1);
        chk("drop_rd0_we", bus.rf_we, 0);
        set_pe0(1'b1, 1'b0, 5'd5, 32'hBEEF);
        set_pe1(1'b1, 1'b0, 5'd7, 32'hCAFE);
        tick();
        chk("drop_rw0_ready", bus.pe0_ready, 1);
        chk("drop_rw0_we", bus.rf_we, 0);
        idle();
        tick();
        chk("drop_after_we", bus.rf_we, 0);
        chk("drop_after_addr", bus.rf_addr, 0);
        tick();
        chk("drop_after2_we", bus.rf_we, 0);

        // Round-robin with simultaneous enqueues
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            if (n <= 3) begin
                set_pe0(1'b1, 1'b1, 5'(n), 32'h100 + 32'(n));
                set_pe1(1'b1, 1'b1, 5'(8 + n), 32'h200 + 32'(8 + n));
            end else begin
                idle();
            end
            tick();
            if (n == 1) begin
                chk("rr_no_bypass", bus.rf_we, 0);
            end else if (n <= 7) begin
                chk("rr_we", bus.rf_we, 1);
                chk("rr_addr", bus.rf_addr, exp_rd[n-2]);
                chk("rr_src", bus.rf_src, (exp_rd[n-2] >= 9) ? 1 : 0);
                chk("rr_data", bus.rf_wdata, ((exp_rd[n-2] >= 9) ? 32'h200 : 32'h100) + 32'(exp_rd[n-2]));
            end else begin
                chk("rr_idle_we", bus.rf_we, 0);
                chk("rr_idle_src_hold", bus.rf_src, 1);
            end
        end
        chk("rr_conflict", conflict_cnt, 5);

        // Back-pressure: PE0 sends 6, PE1 sends 8 while the arbiter alternates
        do_reset();
        for (int i = 0; i < 6; i++) exp_q0.push_back({5'(i + 1), 32'h0A00 + 32'(i + 1)});
        for (int i = 0; i < 8; i++) exp_q1.push_back({5'(17 + i), 32'h0B00 + 32'(17 + i)});
        p0 = 0;
        p1 = 0;
        for (int n = 1; n <= 40; n++) begin
            if (p0 < 6) set_pe0(1'b1, 1'b1, 5'(p0 + 1), 32'h0A00 + 32'(p0 + 1));
            else set_pe0(1'b0, 1'b0, '0, '0);
            if (p1 < 8) set_pe1(1'b1, 1'b1, 5'(17 + p1), 32'h0B00 + 32'(17 + p1));
            else set_pe1(1'b0, 1'b0, '0, '0);
            acc0 = bus.pe0_wb_valid & bus.pe0_ready;
            acc1 = bus.pe1_wb_valid & bus.pe1_ready;
            tick();
            if (acc0) p0++;
            if (acc1) p1++;
            sb_sample();
            if (n == 5) chk("bp_ready_e5", bus.pe1_ready, 1);
            if (n == 6) chk("bp_ready_e6_full", bus.pe1_ready, 0);
            if (n == 7) chk("bp_ready_e7", bus.pe1_ready, 1);
            if (n == 8) chk("bp_ready_e8_full", bus.pe1_ready, 0);
            if (p0 == 6 && p1 == 8 && exp_q0.size() == 0 && exp_q1.size() == 0) break;
        end
        chk("bp_pe0_drained", exp_q0.size(), 0);
        chk("bp_pe1_drained", exp_q1.size(), 0);
        idle();
        tick();
        chk("bp_no_extra_write", bus.rf_we, 0);

        // Reset mid-stream with entries queued
        do_reset();
        for (int n = 1; n <= 3; n++) begin
            set_pe0(1'b1, 1'b1, 5'(n), 32'h300 + 32'(n));
            set_pe1(1'b1, 1'b1, 5'(20 + n), 32'h400 + 32'(n));
            tick();
        end
        idle();
        chk("mid_pre_we", bus.rf_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", bus.rf_we, 0);
        chk("mid_rst_addr", bus.rf_addr, 0);
        chk("mid_rst_pe0_ready", bus.pe0_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            chk("mid_post_we", bus.rf_we, 0);
        end

        // Conflict counter saturation
        do_reset();
        set_pe0(1'b1, 1'b1, 5'd3, 32'h33);
        set_pe1(1'b1, 1'b1, 5'd4, 32'h44);
        for (int n = 1; n <= 25; n++) begin
            tick();
            if (n == 10) chk("sat_count_e10", conflict_cnt, 9);
            if (n == 16) chk("sat_count_e16", conflict_cnt, 15);
            if (n == 25) chk("sat_hold_e25", conflict_cnt, 15);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_pe_wb_arbiter.md
Name: dual_pe_wb_arbiter

Overview:
Writeback merge stage directly downstream of the two processing elements inside Pipeline_top. Each PE's writeback port feeds a private small FIFO. A round-robin arbiter drains the FIFOs into the single shared register-file write port, at up to one write per cycle. Back-pressure to each PE goes through a per-PE ready signal.

Parameters:
XLEN, 32, register data width
RADDR_W, 5, register address width
DEPTH, 4, entries per PE FIFO (power of two, >=2)
CNT_W, 16, width of the conflict statistics counter

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous active-low reset
pe0_wb_valid  in  1  PE0 presents a writeback this cycle
pe0_regwrite  in  1  PE0 writeback actually writes the RF
pe0_rd  in  RADDR_W  PE0 destination register
pe0_wdata  in  XLEN  PE0 result
pe0_ready  out  1  PE0 FIFO can accept (count < DEPTH)
pe1_wb_valid, pe1_regwrite, pe1_rd, pe1_wdata, pe1_ready: same as PE0, for PE1
rf_we  out  1  register-file write enable
rf_addr  out  RADDR_W  register-file write address
rf_wdata  out  XLEN  register-file write data
rf_src  out  1  PE index of the current write (0/1)
conflict_cnt  out  CNT_W  cycles in which both FIFOs were non-empty (saturating)

Behaviour:
- Reset (rst=0, async): both FIFOs empty, rr_ptr=0, rf_we=0, rf_addr=0, rf_wdata=0, rf_src=0, conflict_cnt=0. Reset mid-operation discards all queued entries.
- peN_ready = (countN != DEPTH). This is combinational from the registered count only. A pop in the same cycle does not make a full FIFO ready.
- Enqueue on an edge when peN_wb_valid & peN_ready & peN_regwrite & (peN_rd != 0).
- Valid with regwrite=0, or with rd=0, is consumed and dropped. No entry is stored and the handshake still completes.
- Valid while not ready: the PE holds its inputs. No entry is lost and no entry is duplicated.
- Arbitration uses the registered FIFO state each cycle:
  - Only FIFO0 non-empty: pop FIFO0.
  - Only FIFO1 non-empty: pop FIFO1.
  - Both non-empty: pop FIFO[rr_ptr], then rr_ptr <= ~rr_ptr, and conflict_cnt increments (saturating at all-ones).
  - Neither non-empty: no pop, rr_ptr unchanged.
- Output registers load on the pop edge: rf_we=1, rf_addr/rf_wdata from the head entry, rf_src = FIFO index.
- With no pop, rf_we=0 and addr/data/src hold their previous values.
- Latency: an entry enqueued at edge k is first poppable at edge k+1, so rf_we is visible in the cycle after edge k+1. There is no enqueue-to-output bypass.
- Simultaneous enqueue and pop on the same FIFO (count < DEPTH): count unchanged, pointers both advance.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Ordering is FIFO within each PE. Ordering across PEs is round-robin only; cross-PE RAW/WAW ordering is the dispatcher's responsibility.

Decomposition:
- Shared package holds XLEN, RADDR_W, the default DEPTH, and the wb_entry struct {rd, wdata}.
- One natural sub-module, wb_fifo: a synchronous FIFO with push/pop/full/empty/count, async active-low reset, instantiated twice.
- Arbiter, rr_ptr, output registers and conflict_cnt live in dual_pe_wb_arbiter.

Test Plan:
- Reset mid-stream: fill FIFO0 with 3 entries, assert rst=0 for 1 cycle -> rf_we=0 immediately, pe0_ready=1, no further writes after release.
- Single PE stream: PE0 writes rd=1..4 with data 0x11..0x44 on consecutive edges -> rf_we high for 4 consecutive cycles starting 2 edges after the first valid, addr 1,2,3,4 in order, rf_src=0.
- Round-robin: both PEs enqueue 3 entries on the same edges (PE0 rd=1,2,3; PE1 rd=9,10,11) -> write order 1,9,2,10,3,11 and conflict_cnt=5.
- Back-pressure: hold pe1_wb_valid=1 for 6 edges with the arbiter kept busy by PE0 -> pe1_ready drops once count reaches 4, all 6 PE1 entries eventually written exactly once.
- Drops: PE0 valid with rd=0 data 0xDEAD, then regwrite=0 rd=5 -> no rf_we for either, pe0_ready stays 1.
- Saturation: with CNT_W=4, force both FIFOs non-empty for 20 cycles -> conflict_cnt holds at 15.
